acc_stage: RTL and testbench

Accumulation stage that sits directly upstream of the nonlinear (activation) unit in the PuDianNao datapath. It accepts a stream of signed WIDTH-bit partial products over a valid/ready handshake and sums a programmed number of beats. It holds the finished sum in a single-entry output register, together with the activation function id, until the nonlinear unit's side accepts it. Each `start` produces exactly one result.

---
 rtl/pdn_pkg.sv | 16 +
 rtl/sat_add.sv | 31 +++
 rtl/acc_stage.sv | 142 ++++++++++++++
 tb/tb_acc_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pdn_pkg.sv
// Shared types and constants for the PuDianNao accumulate / nonlinear datapath.
package pdn_pkg;

    // Default datapath width for products, accumulator and results.
    localparam int unsigned DefaultWidth = 32;

    // Activation function selectors forwarded to the nonlinear unit.
    localparam logic [2:0] FUN_RELU = 3'b001;

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StHold
    } acc_state_e;

endpackage

// File: rtl/sat_add.sv
// Combinational signed adder with overflow detection.
// Build option: ACC_SAT_EN clamps on overflow; otherwise the sum wraps.
module sat_add
    import pdn_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

    logic [WIDTH-1:0] raw;

    // Overflow occurs only when both operands share a sign the result does not.
    always_comb begin
        raw = a + b;
        ovf = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
`ifdef ACC_SAT_EN
        if (ovf) begin
            sum = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            sum = raw;
        end
`else
        sum = raw;
`endif
    end

endmodule

// File: rtl/acc_stage.sv
// Accumulation stage feeding the nonlinear unit: sums len signed beats and
// holds the result with its activation id until the downstream accepts it.
// Build option: ACC_SAT_EN selects saturating arithmetic and a live sat flag.
module acc_stage
    import pdn_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [2:0]       fun_id_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       fun_id,
    output logic             busy,
    output logic             sat
);

    acc_state_e       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [2:0]       fun_id_q, fun_id_d;
    logic [WIDTH-1:0] add_sum;
    logic             add_ovf;
    logic             start_ok;

`ifdef ACC_SAT_EN
    logic sat_q, sat_d;
`else
    logic unused_ovf;
    assign unused_ovf = add_ovf;
`endif

    sat_add #(
        .WIDTH(WIDTH)
    ) u_sat_add (
        .a  (acc_q),
        .b  (in_data),
        .sum(add_sum),
        .ovf(add_ovf)
    );

    // Next-state: accumulate in ACC, drain in HOLD, accept start when free.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        out_data_d = out_data_q;
        fun_id_d   = fun_id_q;
`ifdef ACC_SAT_EN
        sat_d      = sat_q;
`endif
        start_ok   = (state_q == StIdle) || ((state_q == StHold) && out_ready);

        unique case (state_q)
            StAcc: begin
                if (in_valid) begin
                    acc_d = add_sum;
                    cnt_d = cnt_q + LEN_W'(1);
`ifdef ACC_SAT_EN
                    if (add_ovf) sat_d = 1'b1;
`endif
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        out_data_d = add_sum;
                        state_d    = StHold;
                    end
                end
            end
            StHold: begin
                if (out_ready) state_d = StIdle;
            end
            default: ;
        endcase

        // A start accepted while leaving HOLD overrides the IDLE transition.
        if (start && start_ok) begin
            fun_id_d = fun_id_in;
`ifdef ACC_SAT_EN
            sat_d    = 1'b0;
`endif
            if (len != '0) begin
                acc_d   = '0;
                cnt_d   = '0;
                len_d   = len;
                state_d = StAcc;
            end else begin
                out_data_d = '0;
                state_d    = StHold;
            end
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            out_data_q <= '0;
            fun_id_q   <= '0;
`ifdef ACC_SAT_EN
            sat_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            out_data_q <= out_data_d;
            fun_id_q   <= fun_id_d;
`ifdef ACC_SAT_EN
            sat_q      <= sat_d;
`endif
        end
    end

    // Outputs decode from registered state only.
    always_comb begin
        in_ready  = (state_q == StAcc);
        out_valid = (state_q == StHold);
        busy      = (state_q != StIdle);
        out_data  = out_data_q;
        fun_id    = fun_id_q;
`ifdef ACC_SAT_EN
        sat       = sat_q;
`else
        sat       = 1'b0;
`endif
    end

endmodule

// File: tb/tb_acc_stage.sv
// Directed self-checking bench for acc_stage.
module tb_acc_stage;
    import pdn_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic [2:0]       fun_id_in = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       fun_id;
    logic             busy;
    logic             sat;

    int compared = 0;
    int mismatched = 0;

    logic [WIDTH-1:0] exp_ovf_data;
    logic             exp_ovf_sat;

    acc_stage #(
        .WIDTH(WIDTH),
        .LEN_W(LEN_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .fun_id_in(fun_id_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .fun_id   (fun_id),
        .busy     (busy),
        .sat      (sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd0);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".out_data"}, out_data, 32'd0);
        check({tag, ".fun_id"}, 32'(fun_id), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".sat"}, 32'(sat), 32'd0);
    endtask

    initial begin
`ifdef ACC_SAT_EN
        exp_ovf_data = 32'h7FFF_FFFF;
        exp_ovf_sat  = 1'b1;
`else
        exp_ovf_data = 32'h8000_0000;
        exp_ovf_sat  = 1'b0;
`endif
        // Reset values
        #1;
        check_reset_outputs("rst");
        step();
        rst = 1'b0;
        step();

        // len=4, back-to-back beats 3,-1,10,2 -> 14
        start = 1'b1; len = 16'd4; fun_id_in = 3'b010; out_ready = 1'b1;
        step();
        start = 1'b0;
        check("t1.in_ready_T+1", 32'(in_ready), 32'd1);
        check("t1.busy", 32'(busy), 32'd1);
        in_valid = 1'b1; in_data = 32'd3;  step();
        in_data = -32'sd1; step();
        in_data = 32'd10;  step();
        check("t1.no_early_valid", 32'(out_valid), 32'd0);
        in_data = 32'd2;   step();
        in_valid = 1'b0;
        check("t1.out_valid", 32'(out_valid), 32'd1);
        check("t1.out_data", out_data, 32'd14);
        check("t1.fun_id", 32'(fun_id), 32'd2);
        check("t1.in_ready_hold", 32'(in_ready), 32'd0);
        step();
        check("t1.idle_busy", 32'(busy), 32'd0);
        check("t1.idle_out_valid", 32'(out_valid), 32'd0);

        // len=3, in_valid toggled, start during ACC ignored, stall in HOLD
        out_ready = 1'b0;
        start = 1'b1; len = 16'd3; fun_id_in = 3'b100;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'd5;   step();
        in_valid = 1'b0; in_data = 32'd100; start = 1'b1; len = 16'd0; step();
        start = 1'b0;
        check("t2.start_ignored_busy", 32'(busy), 32'd1);
        check("t2.start_ignored_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = -32'sd7; step();
        in_valid = 1'b0; in_data = 32'd100; step();
        in_valid = 1'b1; in_data = 32'd20;  step();
        check("t2.out_valid", 32'(out_valid), 32'd1);
        check("t2.out_data", out_data, 32'd18);
        in_data = 32'd55;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2.stall_valid", 32'(out_valid), 32'd1);
            check("t2.stall_data", out_data, 32'd18);
            check("t2.stall_fun", 32'(fun_id), 32'd4);
            check("t2.stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("t2.idle", 32'(busy), 32'd0);

        // len=0 -> result at T+1, data 0, fun_id ReLU
        start = 1'b1; len = 16'd0; fun_id_in = FUN_RELU; out_ready = 1'b0;
        step();
        start = 1'b0;
        check("t3.out_valid", 32'(out_valid), 32'd1);
        check("t3.out_data", out_data, 32'd0);
        check("t3.fun_id", 32'(fun_id), 32'(FUN_RELU));
        check("t3.in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        check("t3.idle", 32'(busy), 32'd0);

        // Overflow: 0x7FFFFFFF + 1
        out_ready = 1'b0;
        start = 1'b1; len = 16'd2; fun_id_in = 3'b011;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'h7FFF_FFFF; step();
        in_data = 32'd1; step();
        in_valid = 1'b0;
        check("t4.out_valid", 32'(out_valid), 32'd1);
        check("t4.out_data", out_data, exp_ovf_data);
        check("t4.sat", 32'(sat), 32'(exp_ovf_sat));

        // Drain and restart in the same cycle, no bubble
        out_ready = 1'b1; start = 1'b1; len = 16'd2; fun_id_in = 3'b110;
        step();
        start = 1'b0;
        check("t5.busy", 32'(busy), 32'd1);
        check("t5.in_ready", 32'(in_ready), 32'd1);
        check("t5.out_valid", 32'(out_valid), 32'd0);
        check("t5.sat_cleared", 32'(sat), 32'd0);
        in_valid = 1'b1; in_data = 32'd4; step();
        in_data = 32'd5; step();
        in_valid = 1'b0;
        check("t5.out_data", out_data, 32'd9);
        check("t5.fun_id", 32'(fun_id), 32'd6);
        check("t5.sat", 32'(sat), 32'd0);
        step();
        check("t5.idle", 32'(busy), 32'd0);

        // Reset mid-sum, then a fresh len=1 job
        out_ready = 1'b0;
        start = 1'b1; len = 16'd5; fun_id_in = 3'b101;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'd1; step();
        in_data = 32'd2; step();
        rst = 1'b1;
        #1;
        check_reset_outputs("t6.async");
        step();
        check_reset_outputs("t6.held");
        rst = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1;
        start = 1'b1; len = 16'd1; fun_id_in = FUN_RELU;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'd7; step();
        in_valid = 1'b0;
        check("t6.out_valid", 32'(out_valid), 32'd1);
        check("t6.out_data", out_data, 32'd7);
        step();
        check("t6.idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
